dl_arb_2x8: RTL and testbench

- Two-requester round-robin arbiter and tag tracker that shares the 8-bit, 8-deep shift delay line (fifo_8b_8d) between two sources.
- Each cycle it grants at most one requester, drives that requester's byte into the delay line, and carries a valid bit and source ID alongside in a matching 8-stage shift pipeline.
- Output is the delayed byte tagged with its source. Sits directly in front of and behind the delay line instance.

---
 rtl/dl_arb_pkg.sv | 22 ++
 rtl/dl_arb_2x8_if.sv | 45 ++++
 rtl/dl_arb_2x8_rr_arb2.sv | 33 +++
 rtl/dl_arb_2x8.sv | 109 ++++++++++
 tb/tb_dl_arb_2x8.sv | 172 +++++++++++++++++
 5 files changed

// File: rtl/dl_arb_pkg.sv
// Shared constants and types for the two-requester delay-line arbiter.
// Consumers: dl_arb_2x8_if, rr_arb2, dl_arb_2x8.
package dl_arb_pkg;

  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned OCC_W = 4;
  localparam int unsigned CNT_W = 16;

  typedef struct packed {
    logic vld;
    logic id;
  } tag_t;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    logic [CNT_W-1:0] r;
    r = (v == '1) ? v : v + 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/dl_arb_2x8_if.sv
// Requester, delay-line and output bundle for dl_arb_2x8.
// DL_ARB_STATS_EN adds stats_clr and the per-requester grant counters.
interface dl_arb_2x8_if;
  import dl_arb_pkg::*;

  logic             req0_valid;
  logic [DW-1:0]    req0_data;
  logic             req0_ready;
  logic             req1_valid;
  logic [DW-1:0]    req1_data;
  logic             req1_ready;
  logic [DW-1:0]    dl_din;
  logic [DW-1:0]    dl_dout;
  logic             out_valid;
  logic             out_id;
  logic [DW-1:0]    out_data;
  logic [OCC_W-1:0] occ;

`ifdef DL_ARB_STATS_EN
  logic             stats_clr;
  logic [CNT_W-1:0] gnt_cnt0;
  logic [CNT_W-1:0] gnt_cnt1;

  modport slave (
    input  req0_valid, req0_data, req1_valid, req1_data, dl_dout, stats_clr,
    output req0_ready, req1_ready, dl_din, out_valid, out_id, out_data, occ,
           gnt_cnt0, gnt_cnt1
  );
  modport master (
    output req0_valid, req0_data, req1_valid, req1_data, dl_dout, stats_clr,
    input  req0_ready, req1_ready, dl_din, out_valid, out_id, out_data, occ,
           gnt_cnt0, gnt_cnt1
  );
`else
  modport slave (
    input  req0_valid, req0_data, req1_valid, req1_data, dl_dout,
    output req0_ready, req1_ready, dl_din, out_valid, out_id, out_data, occ
  );
  modport master (
    output req0_valid, req0_data, req1_valid, req1_data, dl_dout,
    input  req0_ready, req1_ready, dl_din, out_valid, out_id, out_data, occ
  );
`endif

endinterface

// File: rtl/dl_arb_2x8_rr_arb2.sv
// Two-way round-robin grant with its own last-grant register.
// Reset leaves last_grant = 1 so requester 0 wins the first tie.
module rr_arb2 (
  input  logic clk,
  input  logic rst,
  input  logic v0_i,
  input  logic v1_i,
  output logic g0_o,
  output logic g1_o
);

  logic last_q, last_d;

  always_comb begin
    g0_o   = v0_i & (~v1_i | last_q);
    g1_o   = v1_i & (~v0_i | ~last_q);
    last_d = last_q;
    if (g0_o) begin
      last_d = 1'b0;
    end else if (g1_o) begin
      last_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/dl_arb_2x8.sv
// Round-robin front end and tag tracker around an external 8x8 shift delay line.
// Define DL_ARB_STATS_EN to add saturating per-requester grant counters.
module dl_arb_2x8
  import dl_arb_pkg::*;
(
  input logic         clk,
  input logic         rst,
  dl_arb_2x8_if.slave bus
);

  logic g0, g1, gnt_any;

  rr_arb2 u_rr_arb2 (
    .clk  (clk),
    .rst  (rst),
    .v0_i (bus.req0_valid),
    .v1_i (bus.req1_valid),
    .g0_o (g0),
    .g1_o (g1)
  );

  assign gnt_any        = g0 | g1;
  assign bus.req0_ready = g0;
  assign bus.req1_ready = g1;

  always_comb begin
    bus.dl_din = '0;
    if (g0) begin
      bus.dl_din = bus.req0_data;
    end else if (g1) begin
      bus.dl_din = bus.req1_data;
    end
  end

  // Tag pipeline mirrors the delay line stage for stage, so the tail tag
  // always describes the byte currently on dl_dout.
  tag_t [DEPTH-1:0] tag_q;
  tag_t             tag_new;
  tag_t             tag_tail;

  assign tag_new  = '{vld: gnt_any, id: g1};
  assign tag_tail = tag_q[DEPTH-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_q <= '0;
    end else begin
      tag_q <= {tag_q[DEPTH-2:0], tag_new};
    end
  end

  assign bus.out_valid = tag_tail.vld;
  assign bus.out_id    = tag_tail.id;
  assign bus.out_data  = tag_tail.vld ? bus.dl_dout : '0;

  logic [OCC_W-1:0] occ_q, occ_d;

  always_comb begin
    occ_d = occ_q;
    case ({gnt_any, tag_tail.vld})
      2'b10:   occ_d = occ_q + 1'b1;
      2'b01:   occ_d = occ_q - 1'b1;
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_d;
    end
  end

  assign bus.occ = occ_q;

  a_occ_range: assert property (@(posedge clk) disable iff (rst) occ_q <= OCC_W'(DEPTH));

`ifdef DL_ARB_STATS_EN
  logic [CNT_W-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;

  // Clear wins over a coincident grant.
  always_comb begin
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    if (bus.stats_clr) begin
      cnt0_d = '0;
      cnt1_d = '0;
    end else begin
      if (g0) cnt0_d = sat_inc(cnt0_q);
      if (g1) cnt1_d = sat_inc(cnt1_q);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end

  assign bus.gnt_cnt0 = cnt0_q;
  assign bus.gnt_cnt1 = cnt1_q;
`endif

endmodule

// File: tb/tb_dl_arb_2x8.sv
// Scoreboard bench for dl_arb_2x8 with a behavioural 8-stage delay line.
module tb_dl_arb_2x8;
  import dl_arb_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  dl_arb_2x8_if bus ();

  dl_arb_2x8 u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Delay line stand-in: shifts every cycle, cleared by the same reset.
  logic [DEPTH-1:0][DW-1:0] dl_q;
  always @(posedge clk or posedge rst) begin
    if (rst) dl_q <= '0;
    else     dl_q <= {dl_q[DEPTH-2:0], bus.dl_din};
  end
  assign bus.dl_dout = dl_q[DEPTH-1];

  typedef struct {
    int          due;
    logic        id;
    logic [7:0]  data;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every output beat must match the head of the scoreboard in cycle and content.
  always @(negedge clk) begin
    if (sbq.size() > 0 && sbq[0].due < cyc) begin
      total++;
      bad++;
      $display("FAIL missing_out: got none expected id=%0d data=0x%0h due cycle %0d",
               sbq[0].id, sbq[0].data, sbq[0].due);
      void'(sbq.pop_front());
    end
    if (bus.out_valid === 1'b1) begin
      if (sbq.size() == 0 || sbq[0].due != cyc) begin
        total++;
        bad++;
        $display("FAIL unexpected_out: got id=%0d data=0x%0h expected no output (cycle %0d)",
                 bus.out_id, bus.out_data, cyc);
      end else begin
        mon_e = sbq.pop_front();
        chk("out_id", 32'(bus.out_id), 32'(mon_e.id));
        chk("out_data", 32'(bus.out_data), 32'(mon_e.data));
      end
    end else begin
      chk("out_valid_known", 32'(bus.out_valid), 32'd0);
      chk("idle_out_data", 32'(bus.out_data), 32'd0);
    end
  end

  // exp_g: 0 = no grant, 1 = req0, 2 = req1. Entered and left at posedge+1.
  task automatic step(input logic v0, input logic [7:0] d0, input logic v1, input logic [7:0] d1,
                      input int exp_g);
    exp_t e;
    chk("occ", 32'(bus.occ), 32'(sbq.size()));
    bus.req0_valid = v0;
    bus.req0_data  = d0;
    bus.req1_valid = v1;
    bus.req1_data  = d1;
    #1;
    chk("req0_ready", 32'(bus.req0_ready), 32'(exp_g == 1));
    chk("req1_ready", 32'(bus.req1_ready), 32'(exp_g == 2));
    chk("dl_din", 32'(bus.dl_din), (exp_g == 1) ? 32'(d0) : (exp_g == 2) ? 32'(d1) : 32'd0);
    if (exp_g != 0) begin
      e.due  = cyc + int'(DEPTH);
      e.id   = (exp_g == 2);
      e.data = (exp_g == 1) ? d0 : d1;
      sbq.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, 8'h00, 0);
  endtask

  // Pre-reset grants are dropped, so their expectations go too.
  task automatic do_reset(input int hold);
    rst = 1'b1;
    sbq.delete();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    #1;
    chk("rst_occ", 32'(bus.occ), 32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_id", 32'(bus.out_id), 32'd0);
    chk("rst_out_data", 32'(bus.out_data), 32'd0);
`ifdef DL_ARB_STATS_EN
    chk("rst_gnt_cnt0", 32'(bus.gnt_cnt0), 32'd0);
    chk("rst_gnt_cnt1", 32'(bus.gnt_cnt1), 32'd0);
`endif
    repeat (hold) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    bus.req0_valid = 1'b0;
    bus.req0_data  = 8'h00;
    bus.req1_valid = 1'b0;
    bus.req1_data  = 8'h00;
`ifdef DL_ARB_STATS_EN
    bus.stats_clr  = 1'b0;
`endif
    #2;
    do_reset(2);

    // req0 alone, 0x11..0x18 back to back; occ climbs to 8 then drains.
    for (int i = 0; i < 8; i++) step(1'b1, 8'(8'h11 + i), 1'b0, 8'h00, 1);
    idle(10);

    // Both valid from reset: alternate starting with req0, occ pinned at 8 in steady state.
    do_reset(1);
    for (int i = 0; i < 16; i++) step(1'b1, 8'hA0, 1'b1, 8'hB0, (i % 2 == 0) ? 1 : 2);
    idle(9);

    // Single sparse req1 byte.
    idle(3);
    step(1'b0, 8'h00, 1'b1, 8'h5C, 2);
    idle(12);

    // Reset mid-flight after four req0 grants; last_grant was 0, reset must restore 1.
    for (int i = 0; i < 4; i++) step(1'b1, 8'(8'h21 + i), 1'b0, 8'h00, 1);
    do_reset(2);
    step(1'b1, 8'h31, 1'b1, 8'h41, 1);
    step(1'b1, 8'h32, 1'b1, 8'h42, 2);
    idle(12);

`ifdef DL_ARB_STATS_EN
    do_reset(1);
    for (int i = 0; i < 6; i++) step(1'b1, 8'hC0, 1'b1, 8'hD0, (i % 2 == 0) ? 1 : 2);
    step(1'b1, 8'hC6, 1'b0, 8'h00, 1);
    step(1'b1, 8'hC7, 1'b0, 8'h00, 1);
    chk("gnt_cnt0", 32'(bus.gnt_cnt0), 32'd5);
    chk("gnt_cnt1", 32'(bus.gnt_cnt1), 32'd3);
    bus.stats_clr = 1'b1;
    step(1'b1, 8'hC8, 1'b0, 8'h00, 1);
    bus.stats_clr = 1'b0;
    chk("clr_gnt_cnt0", 32'(bus.gnt_cnt0), 32'd0);
    chk("clr_gnt_cnt1", 32'(bus.gnt_cnt1), 32'd0);
    idle(10);
`endif

    chk("sb_drained", 32'(sbq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
